// File: rtl/lcd_word_feeder.sv
// ---------------------------------------------------------------------------
// lcd_word_feeder
//
// Upstream feeder for the 2x16 character LCD driver. Processor words are
// buffered in a small FIFO and handed to the driver one at a time. Each word
// is presented on lcdData with a one-cycle lcdEnable pulse. The driver has no
// busy flag, so every driver reset and every write is followed by a fixed
// hold-off counted in clocks.
//
// Parameters
//   DEPTH      : FIFO entries (power of two, >= 2)
//   RST_WAIT   : clocks held off after an lcdRst pulse (>= 16)
//   WRITE_WAIT : clocks held off after an lcdEnable pulse (>= 97)
//
// Ports
//   clk        in   system clock (feeder posedge, driver samples negedge)
//   rst_n      in   asynchronous active-low reset
//   wordIn     in   18-bit word to display
//   wordValid  in   wordIn valid this cycle
//   wordReady  out  FIFO not full (from registered occupancy)
//   clear      in   single-cycle display re-initialisation request
//   lcdRst     out  registered one-cycle pulse to driver rst
//   lcdEnable  out  registered one-cycle pulse to driver enable
//   lcdData    out  registered word to driver dataIn, changes only on a pop
//   busy       out  high whenever the sequencer is not idle
//
// Build option
//   LCD_FEEDER_DEDUP_EN : when defined, a FIFO head equal to the last word
//                         written since the last driver reset is popped and
//                         dropped without a driver write.
// ---------------------------------------------------------------------------
module lcd_word_feeder #(
  parameter int DEPTH      = 4,
  parameter int RST_WAIT   = 20,
  parameter int WRITE_WAIT = 110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] wordIn,
  input  logic        wordValid,
  output logic        wordReady,
  input  logic        clear,
  output logic        lcdRst,
  output logic        lcdEnable,
  output logic [17:0] lcdData,
  output logic        busy
);

  localparam int DATA_W   = 18;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_MAXV = (RST_WAIT > WRITE_WAIT) ? RST_WAIT : WRITE_WAIT;
  // The hold-off counter only ever holds a value up to CNT_MAXV-1.
  localparam int CNT_W    = $clog2(CNT_MAXV);

  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] TMR_ONE  = CNT_W'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lcd_word_feeder: DEPTH must be a power of two >= 2");
  end
  if (RST_WAIT < 16) begin : g_bad_rst_wait
    $error("lcd_word_feeder: RST_WAIT must be >= 16");
  end
  if (WRITE_WAIT < 97) begin : g_bad_write_wait
    $error("lcd_word_feeder: WRITE_WAIT must be >= 97");
  end

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_RSTWAIT = 3'd1,
    S_IDLE    = 3'd2,
    S_LOAD    = 3'd3,
    S_BUSY    = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;

  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic                r_clear_pend;

  logic                w_push;
  logic                w_pop;
  logic                w_write;
  logic                w_empty;
  logic                w_clear_req;
  logic                w_dup;
  logic                w_lcd_rst_nx;
  logic                w_lcd_en_nx;
  logic [DATA_W-1:0]   w_head;

  // -------------------------------------------------------------------------
  // FIFO status
  // -------------------------------------------------------------------------
  assign wordReady   = (r_count != FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_push      = wordValid && wordReady;
  assign w_head      = r_mem[r_rd_ptr];
  assign busy        = (r_state != S_IDLE);
  // A clear arriving in the same cycle the sequencer sits in IDLE already
  // outranks a pop, so the raw request is folded in with the pending flag.
  assign w_clear_req = r_clear_pend | clear;

`ifdef LCD_FEEDER_DEDUP_EN
  logic [DATA_W-1:0] r_last_word;
  logic              r_last_valid;

  assign w_dup = r_last_valid && (w_head == r_last_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_word  <= '0;
      r_last_valid <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_last_valid <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_last_word  <= lcdData;
      r_last_valid <= 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Sequencer: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer: next state and pop decision
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    w_write    = 1'b0;
    case (r_state)
      S_INIT: begin
        w_state_nx = S_RSTWAIT;
      end
      S_RSTWAIT: begin
        if (r_cnt == '0) w_state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (w_clear_req) begin
          w_state_nx = S_INIT;
        end else if (!w_empty) begin
          w_pop = 1'b1;
          // A duplicate head is consumed but the sequencer stays in IDLE so
          // the following entry is looked at on the next cycle.
          if (!w_dup) begin
            w_write    = 1'b1;
            w_state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        w_state_nx = S_BUSY;
      end
      S_BUSY: begin
        if (r_cnt == '0) w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_INIT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer: output and hold-off counter next values
  // -------------------------------------------------------------------------
  always_comb begin
    w_lcd_rst_nx = (r_state == S_INIT);
    w_lcd_en_nx  = (r_state == S_LOAD);
    w_cnt_nx     = r_cnt;
    case (r_state)
      S_INIT:    w_cnt_nx = RST_LOAD;
      S_LOAD:    w_cnt_nx = WR_LOAD;
      S_RSTWAIT,
      S_BUSY: begin
        if (r_cnt != '0) w_cnt_nx = r_cnt - TMR_ONE;
      end
      default:   w_cnt_nx = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcdRst    <= 1'b0;
      lcdEnable <= 1'b0;
      lcdData   <= '0;
      r_cnt     <= '0;
    end else begin
      lcdRst    <= w_lcd_rst_nx;
      lcdEnable <= w_lcd_en_nx;
      r_cnt     <= w_cnt_nx;
      // lcdData moves only on a writing pop, so it is stable for the whole
      // driver write sequence that follows.
      if (w_write) lcdData <= w_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clear_pend <= 1'b0;
    end else if (r_state == S_IDLE && w_clear_req) begin
      r_clear_pend <= 1'b0;
    end else if (clear) begin
      r_clear_pend <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage and pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wordIn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
